// File: rtl/display_arbiter_if.sv
// Bus between the display arbiter and its pattern sources: requests and patterns in; scan index, grant and display drive out.
// Defining DISPLAY_ARB_DIM_EN adds the brillo brightness input.
interface display_arbiter_if;
  logic       sol_err;
  logic       sol_anim;
  logic [6:0] seg_err;
  logic [6:0] seg_anim;
  logic [6:0] seg_idle;
`ifdef DISPLAY_ARB_DIM_EN
  logic [2:0] brillo;
`endif
  logic [2:0] digito;
  logic       tick_digito;
  logic [2:0] concesion;
  logic [6:0] segmentos;
  logic [7:0] anodos;

  modport master (
    input  sol_err, sol_anim, seg_err, seg_anim, seg_idle,
`ifdef DISPLAY_ARB_DIM_EN
    input  brillo,
`endif
    output digito, tick_digito, concesion, segmentos, anodos
  );

  modport slave (
    output sol_err, sol_anim, seg_err, seg_anim, seg_idle,
`ifdef DISPLAY_ARB_DIM_EN
    output brillo,
`endif
    input  digito, tick_digito, concesion, segmentos, anodos
  );
endinterface

// File: rtl/display_arbiter.sv
// Scan controller and source arbiter for the shared 8-digit active-low 7-segment display.
// Defining DISPLAY_ARB_DIM_EN enables per-slot anode dimming through bus.brillo.
module display_arbiter #(
  parameter int SCAN_DIV = 100000,
  parameter int ERR_HOLD = 500
) (
  input logic               clk,
  input logic               rst,
  display_arbiter_if.master bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(ERR_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(ERR_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_ANIM, S_ERR, S_BLANK} state_t;

  state_t        state;
  state_t        pend;
  state_t        target;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_inc;
  logic [2:0]    digit;
  logic          tick;
  logic [2:0]    grant;
  logic [6:0]    seg_out;
  logic [7:0]    an_out;
  logic [6:0]    seg_sel;
  logic          slot_end;
  logic          frame_end;
  logic          err_done;
  logic          lit;

  function automatic logic [2:0] grant_of(state_t s);
    case (s)
      S_IDLE:  grant_of = 3'b001;
      S_ANIM:  grant_of = 3'b010;
      S_ERR:   grant_of = 3'b100;
      default: grant_of = 3'b000;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit == 3'd7);
  assign target    = bus.sol_err ? S_ERR : (bus.sol_anim ? S_ANIM : S_IDLE);
  assign hold_inc  = (hold == HOLD_MAX) ? hold : hold + HW'(1);
  // The frame ending now counts toward the hold, so exit tests the incremented value.
  assign err_done  = frame_end && (hold_inc == HOLD_MAX) && !bus.sol_err;

`ifdef DISPLAY_ARB_DIM_EN
  logic [31:0] lit_lim;
  assign lit_lim = ((32'(bus.brillo) + 32'd1) * 32'(SCAN_DIV)) >> 3;
  assign lit     = (32'(cnt) < lit_lim);
`else
  assign lit     = 1'b1;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    seg_sel = 7'h7F;
    case (state)
      S_IDLE:  seg_sel = bus.seg_idle;
      S_ANIM:  seg_sel = bus.seg_anim;
      S_ERR:   seg_sel = bus.seg_err;
      default: seg_sel = 7'h7F;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      digit   <= '0;
      tick    <= 1'b0;
      hold    <= '0;
      state   <= S_IDLE;
      pend    <= S_IDLE;
      grant   <= 3'b001;
      an_out  <= 8'hFF;
      seg_out <= 7'h7F;
    end else begin
      cnt  <= slot_end ? '0 : cnt + CW'(1);
      tick <= slot_end;

      if (slot_end) begin
        digit <= digit + 3'd1;
        case (state)
          S_BLANK: begin
            state <= pend;
            grant <= grant_of(pend);
            digit <= '0;
            hold  <= '0;
          end
          S_ERR: begin
            if (frame_end) hold <= hold_inc;
            if (err_done) begin
              state <= S_BLANK;
              pend  <= target;
              grant <= 3'b000;
            end
          end
          default: begin
            // Error preempts on any slot boundary; other changes wait for the frame end.
            if (target == S_ERR || (frame_end && target != state)) begin
              state <= S_BLANK;
              pend  <= target;
              grant <= 3'b000;
            end
          end
        endcase
      end

      seg_out <= seg_sel;
      if (state == S_BLANK || !lit) an_out <= 8'hFF;
      else                          an_out <= ~(8'h80 >> digit);
    end
  end

  assign bus.digito      = digit;
  assign bus.tick_digito = tick;
  assign bus.concesion   = grant;
  assign bus.segmentos   = seg_out;
  assign bus.anodos      = an_out;
endmodule
